noc_input_port: RTL and testbench

Per-direction router input stage. It buffers incoming flits in a small FIFO and computes the XY route from each head flit. For the duration of a wormhole packet it drives a held one-hot request toward the five per-output round-robin arbiters (N,S,E,W,L). It presents the FIFO-head flit to the crossbar and pops it when the granted output accepts it.

---
 rtl/noc_pkg.sv | 27 ++
 rtl/noc_input_port_if.sv | 26 ++
 rtl/noc_fifo.sv | 61 ++++++
 rtl/noc_input_port.sv | 132 +++++++++++++
 tb/tb_noc_input_port.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: output port indices, flit control-bit offsets and
// the input-port FSM state type.
package noc_pkg;

    localparam int PORT_N    = 0;
    localparam int PORT_S    = 1;
    localparam int PORT_E    = 2;
    localparam int PORT_W    = 3;
    localparam int PORT_L    = 4;
    localparam int NUM_PORTS = 5;

    localparam logic [2:0] NO_GRANT = 3'b111;

    // Control bits sit directly above the payload: flit[DATA_W + HEAD_BIT].
    localparam int HEAD_BIT = 1;
    localparam int TAIL_BIT = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ROUTED = 1'b1
    } state_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input int idx);
        return NUM_PORTS'(1) << idx;
    endfunction

endpackage

// File: rtl/noc_input_port_if.sv
// Upstream flit link plus crossbar/arbiter side of one router input port.
interface noc_input_port_if #(
    parameter int DATA_W = 32
);
    // Handshakes: a push happens on a rising edge where valid_i && ready_o; a
    // pop happens where valid_o && out_ready_i. ready_o, valid_o and req_o are
    // registered-state functions and never depend combinationally on inputs.
    logic [DATA_W+1:0]              flit_i;
    logic                           valid_i;
    logic                           ready_o;
    logic [noc_pkg::NUM_PORTS-1:0]  req_o;
    logic [DATA_W+1:0]              flit_o;
    logic                           valid_o;
    logic                           out_ready_i;
    logic                           err_o;

    modport slave (
        input  flit_i, valid_i, out_ready_i,
        output ready_o, req_o, flit_o, valid_o, err_o
    );

    modport master (
        output flit_i, valid_i, out_ready_i,
        input  ready_o, req_o, flit_o, valid_o, err_o
    );
endinterface

// File: rtl/noc_fifo.sv
// Synchronous circular-buffer FIFO; pointers wrap naturally, so DEPTH must be
// a power of two. Push when full and pop when empty are ignored.
module noc_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rd_data = mem[rd_ptr];
    assign count   = count_q;

    // Storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/noc_input_port.sv
// Router input stage: buffers flits, XY-routes each head flit and holds a
// one-hot output request for the whole wormhole packet.
module noc_input_port
    import noc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    noc_input_port_if.slave         port,
    output state_t                  dbg_state
);

    localparam int              FW        = DATA_W + 2;
    localparam int              CW        = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);
    localparam logic [X_W-1:0]  MY_XV     = X_W'(MY_X);
    localparam logic [Y_W-1:0]  MY_YV     = Y_W'(MY_Y);

    logic [FW-1:0]          fifo_head;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_push;
    logic                   fifo_pop;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   route_q, route_d;
    logic [NUM_PORTS-1:0]   route_calc;
    logic                   err_q, err_d;
    logic [NUM_PORTS-1:0]   req;
    logic                   valid;

    logic                   head_flag;
    logic                   tail_flag;
    logic [X_W-1:0]         dest_x;
    logic [Y_W-1:0]         dest_y;

    assign port.ready_o = (fifo_count != DEPTH_CNT);
    assign fifo_push    = port.valid_i && port.ready_o;

    noc_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (port.flit_i),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head_flag = fifo_head[DATA_W + HEAD_BIT];
    assign tail_flag = fifo_head[DATA_W + TAIL_BIT];
    assign dest_x    = fifo_head[X_W+Y_W-1:Y_W];
    assign dest_y    = fifo_head[Y_W-1:0];

    // Dimension-ordered routing: resolve X fully before Y.
    always_comb begin
        if (dest_x > MY_XV) begin
            route_calc = port_onehot(PORT_E);
        end else if (dest_x < MY_XV) begin
            route_calc = port_onehot(PORT_W);
        end else if (dest_y > MY_YV) begin
            route_calc = port_onehot(PORT_N);
        end else if (dest_y < MY_YV) begin
            route_calc = port_onehot(PORT_S);
        end else begin
            route_calc = port_onehot(PORT_L);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            route_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        route_d  = route_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        req      = '0;
        valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_flag) begin
                        route_d = route_calc;
                        state_d = ST_ROUTED;
                    end else begin
                        // Orphan body/tail flit: drop it and flag the protocol error.
                        fifo_pop = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
            ST_ROUTED: begin
                req      = route_q;
                valid    = !fifo_empty;
                fifo_pop = !fifo_empty && port.out_ready_i;
                if (fifo_pop && tail_flag) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign port.req_o   = req;
    assign port.valid_o = valid;
    assign port.flit_o  = fifo_head;
    assign port.err_o   = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_noc_input_port.sv
// Directed and randomized checks of noc_input_port at router position (1,1).
module tb_noc_input_port;
  import noc_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int FW     = DATA_W + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_input_port_if #(.DATA_W(DATA_W)) bus ();
  state_t dbg_state;

  noc_input_port #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .X_W    (2),
    .Y_W    (2),
    .MY_X   (1),
    .MY_Y   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .port      (bus),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // scoreboard: flits accepted and not yet delivered, with the route each must use
  logic [FW-1:0] exp_q[$];
  logic [4:0]    route_q[$];
  logic [4:0]    cur_route = '0;
  bit            track = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // XY routing reference for MY=(1,1)
  function automatic logic [4:0] xy(input logic [1:0] dx, input logic [1:0] dy);
    if (dx > 2'd1) return 5'b00100;
    if (dx < 2'd1) return 5'b01000;
    if (dy > 2'd1) return 5'b00001;
    if (dy < 2'd1) return 5'b00010;
    return 5'b10000;
  endfunction

  function automatic logic [FW-1:0] mk(input bit h, input bit t, input logic [1:0] dx,
                                       input logic [1:0] dy);
    logic [27:0] r;
    r = 28'($urandom);
    return {h, t, r, dx, dy};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    bit push;
    bit pop;
    bit was_tail;
    push = bus.valid_i && bus.ready_o;
    pop = bus.valid_o && bus.out_ready_i;
    was_tail = 1'b0;
    if (track) begin
      check("ready_o", bus.ready_o, exp_q.size() != DEPTH);
      if (bus.valid_o) begin
        if (exp_q.size() == 0) begin
          check("valid_o_empty", bus.valid_o, 0);
        end else begin
          check("flit_o", bus.flit_o, exp_q[0]);
          check("req_o", bus.req_o, route_q[0]);
        end
      end
      if (pop && exp_q.size() > 0) begin
        was_tail = exp_q[0][DATA_W];
        void'(exp_q.pop_front());
        void'(route_q.pop_front());
      end
      if (push) begin
        if (bus.flit_i[DATA_W+1]) cur_route = xy(bus.flit_i[3:2], bus.flit_i[1:0]);
        exp_q.push_back(bus.flit_i);
        route_q.push_back(cur_route);
      end
    end
    step();
    if (track && was_tail) begin
      check("bubble_req", bus.req_o, 0);
      check("bubble_valid", bus.valid_o, 0);
    end
  endtask

  logic [1:0]    sx[4]   = '{2'd1, 2'd1, 2'd1, 2'd0};
  logic [1:0]    sy[4]   = '{2'd2, 2'd0, 2'd1, 2'd3};
  logic [4:0]    sexp[4] = '{5'b00001, 5'b00010, 5'b10000, 5'b01000};
  logic [FW-1:0] in_q[$];
  logic [FW-1:0] f[4];
  bit            acc;

  initial begin
    bus.flit_i = '0;
    bus.valid_i = 1'b0;
    bus.out_ready_i = 1'b0;

    // reset and idle
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("rst_ready", bus.ready_o, 1);
    check("rst_req", bus.req_o, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_err", bus.err_o, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // three-flit packet to (3,1) -> E
    bus.out_ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.flit_i = mk(1, 0, 2'd3, 2'd1);
    cycle();
    check("pkt_lat_req", bus.req_o, 0);
    check("pkt_lat_state", dbg_state, ST_IDLE);
    bus.flit_i = mk(0, 0, 2'd0, 2'd0);
    cycle();
    check("pkt_req_e", bus.req_o, 5'b00100);
    check("pkt_state", dbg_state, ST_ROUTED);
    bus.flit_i = mk(0, 1, 2'd2, 2'd3);
    cycle();
    bus.valid_i = 1'b0;
    repeat (3) cycle();
    check("pkt_drained", exp_q.size(), 0);

    // single-flit packets to each non-E direction
    for (int i = 0; i < 4; i++) begin
      bus.valid_i = 1'b1;
      bus.flit_i = mk(1, 1, sx[i], sy[i]);
      cycle();
      bus.valid_i = 1'b0;
      check("single_lat", bus.req_o, 0);
      cycle();
      check("single_route", bus.req_o, sexp[i]);
      cycle();
    end

    // fill to DEPTH with output stalled, then pop while upstream keeps pushing
    bus.out_ready_i = 1'b0;
    f[0] = mk(1, 0, 2'd2, 2'd1);
    f[1] = mk(0, 0, 2'd0, 2'd0);
    f[2] = mk(0, 0, 2'd1, 2'd2);
    f[3] = mk(0, 1, 2'd3, 2'd3);
    for (int i = 0; i < 4; i++) begin
      bus.valid_i = 1'b1;
      bus.flit_i = f[i];
      cycle();
    end
    bus.flit_i = mk(1, 1, 2'd1, 2'd1);
    check("full_ready", bus.ready_o, 0);
    cycle();
    check("full_hold_ready", bus.ready_o, 0);
    check("full_hold_valid", bus.valid_o, 1);
    bus.out_ready_i = 1'b1;
    cycle();
    check("after_pop_ready", bus.ready_o, 1);
    cycle();
    check("push_pop_ready", bus.ready_o, 1);
    check("push_pop_req", bus.req_o, 5'b00100);
    bus.valid_i = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) cycle();
    cycle();
    check("full_drained", exp_q.size(), 0);

    // orphan body flit in IDLE is dropped and flags an error
    track = 1'b0;
    bus.valid_i = 1'b1;
    bus.flit_i = mk(0, 0, 2'd3, 2'd3);
    step();
    bus.valid_i = 1'b0;
    check("orphan_valid0", bus.valid_o, 0);
    check("orphan_err_pre", bus.err_o, 0);
    step();
    check("orphan_err", bus.err_o, 1);
    check("orphan_valid1", bus.valid_o, 0);
    check("orphan_ready", bus.ready_o, 1);
    check("orphan_req", bus.req_o, 0);
    step();
    check("err_sticky", bus.err_o, 1);
    track = 1'b1;
    bus.valid_i = 1'b1;
    bus.flit_i = mk(1, 1, 2'd0, 2'd3);
    cycle();
    bus.valid_i = 1'b0;
    cycle();
    check("after_err_route", bus.req_o, 5'b01000);
    repeat (2) cycle();
    check("err_still_set", bus.err_o, 1);

    // asynchronous reset in the middle of a packet
    bus.out_ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.flit_i = mk(1, 0, 2'd0, 2'd0);
    cycle();
    bus.flit_i = mk(0, 0, 2'd1, 2'd1);
    cycle();
    bus.valid_i = 1'b0;
    check("pre_reset_req", bus.req_o, 5'b01000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", bus.req_o, 0);
    check("async_valid", bus.valid_o, 0);
    check("async_ready", bus.ready_o, 1);
    check("async_err", bus.err_o, 0);
    check("async_state", dbg_state, ST_IDLE);
    exp_q.delete();
    route_q.delete();
    #2;
    rst_n = 1'b1;
    step();
    check("post_reset_valid", bus.valid_o, 0);
    check("post_reset_req", bus.req_o, 0);
    check("post_reset_ready", bus.ready_o, 1);

    // randomized packet stream with random upstream gaps and output stalls
    for (int p = 0; p < 30; p++) begin
      int len;
      logic [1:0] dx;
      logic [1:0] dy;
      len = $urandom_range(1, 4);
      dx = 2'($urandom_range(0, 3));
      dy = 2'($urandom_range(0, 3));
      for (int k = 0; k < len; k++) begin
        in_q.push_back(mk(k == 0, k == len - 1, (k == 0) ? dx : 2'($urandom), (k == 0) ? dy : 2'($urandom)));
      end
    end
    for (int c = 0; c < 4000 && (in_q.size() > 0 || exp_q.size() > 0); c++) begin
      bus.valid_i = (in_q.size() > 0) && ($urandom_range(0, 3) != 0);
      bus.flit_i = (in_q.size() > 0) ? in_q[0] : '0;
      bus.out_ready_i = ($urandom_range(0, 2) != 0);
      acc = bus.valid_i && bus.ready_o;
      cycle();
      if (acc) void'(in_q.pop_front());
    end
    check("random_done", in_q.size() + exp_q.size(), 0);

    bus.valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    step();
    check("final_req", bus.req_o, 0);
    check("final_err", bus.err_o, 0);
    check("final_ready", bus.ready_o, 1);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
